// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS code words, mode enum and small helpers for the encoder.
package tmds_pkg;
    typedef enum logic [1:0] {VIDEO, GUARD, TERC4, CONTROL} tmds_mode_e;
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;
    localparam logic [9:0] VIDEO_GUARD  = 10'b1011001100;
    localparam logic [9:0] ISLAND_GUARD = 10'b0100110011;
    localparam logic [9:0] TERC4_0 = 10'b1010011100;
    localparam logic [9:0] TERC4_1 = 10'b1001100011;
    localparam logic [9:0] TERC4_2 = 10'b1011100100;
    localparam logic [9:0] TERC4_3 = 10'b1011100010;
    localparam logic [9:0] TERC4_4 = 10'b0101110001;
    localparam logic [9:0] TERC4_5 = 10'b0100011110;
    localparam logic [9:0] TERC4_6 = 10'b0110001110;
    localparam logic [9:0] TERC4_7 = 10'b0100111100;
    localparam logic [9:0] TERC4_8 = 10'b1011001100;
    localparam logic [9:0] TERC4_9 = 10'b0100111001;
    localparam logic [9:0] TERC4_A = 10'b0110011100;
    localparam logic [9:0] TERC4_B = 10'b1011000110;
    localparam logic [9:0] TERC4_C = 10'b1010001110;
    localparam logic [9:0] TERC4_D = 10'b1001110001;
    localparam logic [9:0] TERC4_E = 10'b0101100011;
    localparam logic [9:0] TERC4_F = 10'b1011000011;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, d[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctrl_word(input logic [1:0] s);
        return s[1] ? (s[0] ? CTRL_11 : CTRL_10) : (s[0] ? CTRL_01 : CTRL_00);
    endfunction

    function automatic logic [9:0] terc4_word(input logic [3:0] c);
        case (c)
            4'h0: return TERC4_0;
            4'h1: return TERC4_1;
            4'h2: return TERC4_2;
            4'h3: return TERC4_3;
            4'h4: return TERC4_4;
            4'h5: return TERC4_5;
            4'h6: return TERC4_6;
            4'h7: return TERC4_7;
            4'h8: return TERC4_8;
            4'h9: return TERC4_9;
            4'hA: return TERC4_A;
            4'hB: return TERC4_B;
            4'hC: return TERC4_C;
            4'hD: return TERC4_D;
            4'hE: return TERC4_E;
            default: return TERC4_F;
        endcase
    endfunction
endpackage

// File: rtl/tmds_8b10b_encoder_qm_stage.sv
// tmds_qm_stage: first pipeline stage -- mode select, transition-minimised q_m and payload register.
// TMDS_TERC4_EN enables the guard and TERC4 modes; otherwise only video and control are selected.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data,
    input  logic [1:0] sync,
    input  logic       ctrl_valid,
    input  logic [3:0] ctrl,
    input  logic       guard,
    output logic [1:0] mode_q,
    output logic [8:0] qm_q,
    output logic [1:0] sync_q,
    output logic [3:0] ctrl_q
);
    tmds_mode_e mode_d;
    logic [8:0] qm_d;
    logic [3:0] n1;
    logic       use_xnor;

    always_comb begin
        n1 = ones8(data);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !data[0]);
        qm_d = '0;
        qm_d[0] = data[0];
        for (int i = 1; i < 8; i++) qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
        qm_d[8] = ~use_xnor;
`ifdef TMDS_TERC4_EN
        mode_d = data_valid ? VIDEO : guard ? GUARD : ctrl_valid ? TERC4 : CONTROL;
`else
        mode_d = data_valid ? VIDEO : CONTROL;
`endif
    end

`ifndef TMDS_TERC4_EN
    logic unused_island;
    assign unused_island = ^{ctrl_valid, guard};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= CONTROL;
            qm_q   <= '0;
            sync_q <= '0;
            ctrl_q <= '0;
        end else begin
            mode_q <= mode_d;
            qm_q   <= qm_d;
            sync_q <= sync;
            ctrl_q <= ctrl;
        end
    end
endmodule

// File: rtl/tmds_8b10b_encoder.sv
// tmds_8b10b_encoder: two-stage TMDS encoder with running disparity for video words.
// TMDS_TERC4_EN enables guard-band and TERC4 data-island words; otherwise those cycles send control words.
module tmds_8b10b_encoder
    import tmds_pkg::*;
#(
    parameter logic [9:0] GUARD_WORD = VIDEO_GUARD
) (
    input  logic       hdmi_clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data,
    input  logic [1:0] sync,
    input  logic       ctrl_valid,
    input  logic [3:0] ctrl,
    input  logic       guard,
    output logic [9:0] out
);
    tmds_mode_e        mode;
    logic [1:0]        mode_raw;
    logic [1:0]        sync_q;
    logic [8:0]        qm_q;
    logic [3:0]        ctrl_q;
    logic [3:0]        n1;
    logic [9:0]        out_d, out_q;
    logic signed [4:0] cnt_d, cnt_q, diff;

    tmds_qm_stage u_qm (
        .clk        (hdmi_clk),
        .reset      (reset),
        .data_valid (data_valid),
        .data       (data),
        .sync       (sync),
        .ctrl_valid (ctrl_valid),
        .ctrl       (ctrl),
        .guard      (guard),
        .mode_q     (mode_raw),
        .qm_q       (qm_q),
        .sync_q     (sync_q),
        .ctrl_q     (ctrl_q)
    );

    always_comb begin
        mode = tmds_mode_e'(mode_raw);
        n1 = ones8(qm_q[7:0]);
        diff = $signed({n1, 1'b0}) - 5'sd8;  // N1 - N0
        if (cnt_q == 0 || diff == 0) begin
            out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
        end else if ((cnt_q > 0 && diff > 0) || (cnt_q < 0 && diff < 0)) begin
            out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            out_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff;
        end
        if (mode != VIDEO) begin
            cnt_d = '0;
`ifdef TMDS_TERC4_EN
            out_d = mode == GUARD ? GUARD_WORD : mode == TERC4 ? terc4_word(ctrl_q) : ctrl_word(sync_q);
`else
            out_d = ctrl_word(sync_q);
`endif
        end
    end

`ifndef TMDS_TERC4_EN
    logic unused_island;
    assign unused_island = ^{ctrl_q, GUARD_WORD};
`endif

    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            out_q <= CTRL_00;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign out = out_q;
endmodule
